// File: rtl/spmv_pkg.sv
// Shared types and constants for the CSR sparse-matrix x multi-vector engine.
package spmv_pkg;
  typedef enum logic [2:0] {IDLE, PTR0, PTR1, MAC, DRAIN, EMIT, FIN} state_e;

  localparam int MAC_LAT   = 4;
  localparam int DEF_LANES = 2;
  localparam int DEF_DW    = 32;
  localparam int DEF_AW    = 14;
  localparam int DEF_RW    = 10;
endpackage

// File: rtl/spmv_mac_lane.sv
// One dense-vector lane: registered signed product feeding a wrapping accumulator.
module spmv_mac_lane #(
  parameter int DW   = 32,
  parameter int ACCW = 2*DW+8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   prod_en_i,
  input  logic                   acc_en_i,
  input  logic signed [DW-1:0]   a_i,
  input  logic signed [DW-1:0]   b_i,
  output logic signed [ACCW-1:0] acc_o
);
  logic signed [2*DW-1:0] prod_q;
  logic signed [ACCW-1:0] acc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      if (prod_en_i) prod_q <= (2*DW)'(a_i) * (2*DW)'(b_i);
      if (clr_i)         acc_q <= '0;
      else if (acc_en_i) acc_q <= acc_q + ACCW'(prod_q);
    end
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/csr_spmv_lanes.sv
// Row-by-row CSR SpMV against LANES dense vectors; one nonzero issued per cycle,
// one result beat per row with valid/ready back-pressure.
module csr_spmv_lanes
  import spmv_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW,
  parameter int RW    = DEF_RW,
  parameter int ACCW  = 2*DW+8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [RW-1:0]         nrows,
  output logic [RW-1:0]         row_addr,
  input  logic [AW-1:0]         row_data,
  output logic [AW-1:0]         nz_addr,
  input  logic [DW-1:0]         nz_val,
  input  logic [RW-1:0]         nz_col,
  output logic [RW-1:0]         vec_addr,
  input  logic [LANES*DW-1:0]   vec_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RW-1:0]         out_row,
  output logic [LANES*ACCW-1:0] out_data,
  output logic                  out_zero,
  output logic                  busy,
  output logic                  done
);
  state_e state_q, state_d;
  logic [RW-1:0] nrows_q, nrows_d, row_q, row_d, row_addr_q, row_addr_d;
  logic [AW-1:0] lo_q, lo_d, hi_q, hi_d, nz_addr_q, nz_addr_d;
  logic zero_q, zero_d, clr, issue;
  logic [MAC_LAT-2:0] pipe_q;
  logic signed [DW-1:0] val_q;

  // row_addr always runs one entry ahead so each PTR state sees its word on arrival.
  always_comb begin
    state_d    = state_q;
    nrows_d    = nrows_q;
    row_d      = row_q;
    row_addr_d = row_addr_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    nz_addr_d  = nz_addr_q;
    zero_d     = zero_q;
    clr        = 1'b0;
    issue      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        nrows_d = nrows;
        row_d   = '0;
        if (nrows == '0) begin
          state_d = FIN;
        end else begin
          state_d    = PTR0;
          row_addr_d = RW'(1);
          clr        = 1'b1;
        end
      end
      PTR0: begin
        lo_d    = row_data;
        state_d = PTR1;
      end
      PTR1: begin
        hi_d      = row_data;
        nz_addr_d = lo_q;
        zero_d    = !(row_data > lo_q);
        state_d   = (row_data > lo_q) ? MAC : EMIT;
      end
      MAC: begin
        issue     = 1'b1;
        nz_addr_d = nz_addr_q + AW'(1);
        if (nz_addr_q + AW'(1) == hi_q) state_d = DRAIN;
      end
      DRAIN: if (pipe_q == '0) state_d = EMIT;
      EMIT: if (out_ready) begin
        if (row_q + RW'(1) == nrows_q) begin
          state_d = FIN;
        end else begin
          state_d    = PTR0;
          row_d      = row_q + RW'(1);
          row_addr_d = row_addr_q + RW'(1);
          clr        = 1'b1;
        end
      end
      FIN: begin
        state_d    = IDLE;
        row_addr_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      nrows_q    <= '0;
      row_q      <= '0;
      row_addr_q <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      nz_addr_q  <= '0;
      zero_q     <= 1'b0;
      pipe_q     <= '0;
      val_q      <= '0;
    end else begin
      state_q    <= state_d;
      nrows_q    <= nrows_d;
      row_q      <= row_d;
      row_addr_q <= row_addr_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      nz_addr_q  <= nz_addr_d;
      zero_q     <= zero_d;
      pipe_q     <= {pipe_q[MAC_LAT-3:0], issue};
      if (pipe_q[0]) val_q <= nz_val;
    end
  end

  // pipe_q[0]: val/col returned, [1]: vec_data returned, [2]: product registered.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    spmv_mac_lane #(.DW(DW), .ACCW(ACCW)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (clr),
      .prod_en_i (pipe_q[1]),
      .acc_en_i  (pipe_q[2]),
      .a_i       (val_q),
      .b_i       (vec_data[gi*DW +: DW]),
      .acc_o     (out_data[gi*ACCW +: ACCW])
    );
  end

  assign row_addr  = row_addr_q;
  assign nz_addr   = nz_addr_q;
  assign vec_addr  = pipe_q[0] ? nz_col : '0;
  assign out_valid = (state_q == EMIT);
  assign out_row   = row_q;
  assign out_zero  = out_valid && zero_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
endmodule

// File: tb/tb_csr_spmv_lanes.sv
// Directed bench for csr_spmv_lanes with a result scoreboard and wide-lane instances.
module tb_csr_spmv_lanes;
  localparam int L = 2, DW = 32, AW = 14, RW = 10, ACCW = 2*DW+8;

  typedef struct packed {
    logic [RW-1:0]     row;
    logic [L*ACCW-1:0] data;
    logic              zero;
  } exp_t;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [RW-1:0] nrows = '0;
  logic [RW-1:0] row_addr, vec_addr, nz_col, out_row;
  logic [AW-1:0] row_data, nz_addr;
  logic [DW-1:0] nz_val;
  logic [L*DW-1:0] vec_data;
  logic [L*ACCW-1:0] out_data;
  logic out_valid, out_zero, busy, done;

  logic [AW-1:0]        row_mem [0:1023];
  logic signed [DW-1:0] val_mem [0:1023];
  logic [RW-1:0]        col_mem [0:1023];
  logic [L*DW-1:0]      vec_mem [0:1023];

  exp_t sb[$];
  int passed = 0, total = 0, done_cnt = 0;

  always #5 clk = ~clk;

  csr_spmv_lanes #(.LANES(L), .DW(DW), .AW(AW), .RW(RW), .ACCW(ACCW)) dut (
    .clk(clk), .rst(rst), .start(start), .nrows(nrows),
    .row_addr(row_addr), .row_data(row_data),
    .nz_addr(nz_addr), .nz_val(nz_val), .nz_col(nz_col),
    .vec_addr(vec_addr), .vec_data(vec_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_data(out_data), .out_zero(out_zero), .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    row_data <= row_mem[row_addr];
    nz_val   <= val_mem[nz_addr[9:0]];
    nz_col   <= col_mem[nz_addr[9:0]];
    vec_data <= vec_mem[vec_addr];
  end

  // DW=8 instances with LANES = 1, 2, 4: one row of 300 nonzeros, all 127*127.
  logic start_w = 1'b0;
  logic [2:0] w_got;
  logic [2:0] w_zero;
  logic [4*24-1:0] w_cap [3];
  for (genvar gi = 0; gi < 3; gi++) begin : g_w
    localparam int LN = 1 << gi;
    logic [RW-1:0] ra, va, nc, orow;
    logic [AW-1:0] rd, na;
    logic [7:0] nv;
    logic [LN*8-1:0] vd;
    logic [LN*24-1:0] od;
    logic ov, oz, bz, dn;
    csr_spmv_lanes #(.LANES(LN), .DW(8), .AW(AW), .RW(RW), .ACCW(24)) u_w (
      .clk(clk), .rst(rst), .start(start_w), .nrows(10'd1),
      .row_addr(ra), .row_data(rd), .nz_addr(na), .nz_val(nv), .nz_col(nc),
      .vec_addr(va), .vec_data(vd), .out_valid(ov), .out_ready(1'b1),
      .out_row(orow), .out_data(od), .out_zero(oz), .busy(bz), .done(dn)
    );
    always @(posedge clk) begin
      rd <= (ra == 10'd1) ? 14'd300 : 14'd0;
      nv <= 8'd127;
      nc <= na[RW-1:0];
      vd <= {LN{8'd127}};
    end
    always @(negedge clk) begin
      if (!rst) w_got[gi] <= 1'b0;
      else if (ov) begin
        w_got[gi]  <= 1'b1;
        w_cap[gi]  <= 96'(od);
        w_zero[gi] <= oz;
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int r, input int a, input int b, input logic z);
    exp_t e;
    e.row  = RW'(r);
    e.data = {ACCW'(b), ACCW'(a)};
    e.zero = z;
    return e;
  endfunction

  // Reference model straight from the CSR arrays held by the bench.
  function automatic exp_t model_row(input int r);
    exp_t e;
    int lo, hi;
    logic signed [ACCW-1:0] acc;
    logic signed [DW-1:0] x;
    lo = int'(row_mem[r]);
    hi = int'(row_mem[r+1]);
    e.row  = RW'(r);
    e.data = '0;
    e.zero = (hi <= lo);
    for (int i = 0; i < L; i++) begin
      acc = '0;
      for (int k = lo; k < hi; k++) begin
        x   = vec_mem[col_mem[k]][i*DW +: DW];
        acc = acc + ACCW'(val_mem[k]) * ACCW'(x);
      end
      e.data[i*ACCW +: ACCW] = acc;
    end
    return e;
  endfunction

  // Scoreboard: pop and compare on every accepted result beat.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 256'(out_valid), 256'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_row",  256'(out_row),  256'(e.row));
        check("out_data", 256'(out_data), 256'(e.data));
        check("out_zero", 256'(out_zero), 256'(e.zero));
      end
    end
    if (rst && done) done_cnt++;
  end

  initial begin
    int n;
    logic [255:0] snap, cur;
    for (int k = 0; k < 1024; k++) begin
      row_mem[k] = '0; val_mem[k] = '0; col_mem[k] = '0; vec_mem[k] = '0;
    end

    tick(3);
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_valid", 256'(out_valid), 256'(0));
    check("rst_addrs", 256'({row_addr, nz_addr, vec_addr}), 256'(0));
    check("rst_data", 256'({out_data, out_zero, out_row}), 256'(0));
    rst = 1'b1;
    tick(2);

    // 3x3 matrix {2,0,0},{0,0,0},{1,0,3}; x0={1,2,3}, x1={-1,4,5}
    row_mem[0] = 0; row_mem[1] = 1; row_mem[2] = 1; row_mem[3] = 3;
    val_mem[0] = 2; val_mem[1] = 1; val_mem[2] = 3;
    col_mem[0] = 0; col_mem[1] = 0; col_mem[2] = 2;
    vec_mem[0] = {-32'sd1, 32'sd1};
    vec_mem[1] = {32'sd4, 32'sd2};
    vec_mem[2] = {32'sd5, 32'sd3};
    sb.push_back(mk(0, 2, -2, 1'b0));
    sb.push_back(mk(1, 0, 0, 1'b1));
    sb.push_back(mk(2, 10, 14, 1'b0));
    done_cnt = 0;
    nrows = 10'd3; out_ready = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin tick(1); n++; end
    check("row0_valid_seen", 256'(out_valid), 256'(1));
    snap = 256'({out_valid, out_row, out_data, out_zero, row_addr, nz_addr, vec_addr});
    // Hold off ready for 10 cycles; a start pulse mid-stall must be ignored.
    for (int c = 0; c < 10; c++) begin
      start = (c == 4);
      if (c == 4) nrows = 10'd0;
      tick(1);
      cur = 256'({out_valid, out_row, out_data, out_zero, row_addr, nz_addr, vec_addr});
      check("stall_hold", cur, snap);
    end
    start = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (busy && n < 200) begin tick(1); n++; end
    check("job1_finished", 256'(busy), 256'(0));
    check("job1_done_pulses", 256'(done_cnt), 256'(1));
    check("job1_sb_empty", 256'(sb.size()), 256'(0));

    // nrows=0: IDLE->FIN->IDLE
    done_cnt = 0; nrows = 10'd0; start = 1'b1;
    tick(1);
    start = 1'b0;
    check("n0_done_high", 256'({done, busy}), 256'(2'b11));
    tick(1);
    check("n0_done_low", 256'({done, busy}), 256'(2'b00));
    tick(2);
    check("n0_done_pulses", 256'(done_cnt), 256'(1));

    // 4-row job, reset asserted while row 1 is in MAC
    row_mem[0] = 0; row_mem[1] = 2; row_mem[2] = 8; row_mem[3] = 9; row_mem[4] = 10;
    for (int k = 0; k < 10; k++) begin
      val_mem[k] = k*7 - 20;
      col_mem[k] = RW'(k % 3);
    end
    sb.push_back(model_row(0));
    nrows = 10'd4; start = 1'b1;
    tick(1);
    start = 1'b0;
    n = 0;
    while (nz_addr != 14'd4 && n < 100) begin tick(1); n++; end
    check("row1_mac_reached", 256'(nz_addr), 256'(4));
    #2 rst = 1'b0;
    #1;
    check("abort_flags", 256'({busy, done, out_valid, out_zero}), 256'(0));
    check("abort_addrs", 256'({row_addr, nz_addr, vec_addr}), 256'(0));
    check("abort_data", 256'({out_row, out_data}), 256'(0));
    tick(2);
    rst = 1'b1;
    tick(30);
    check("abort_stays_idle", 256'(busy), 256'(0));
    check("abort_sb_empty", 256'(sb.size()), 256'(0));

    // Same 4-row job run to completion after the abort
    for (int r = 0; r < 4; r++) sb.push_back(model_row(r));
    done_cnt = 0; start = 1'b1;
    tick(1);
    start = 1'b0;
    n = 0;
    while (busy && n < 300) begin tick(1); n++; end
    check("job4_finished", 256'(busy), 256'(0));
    check("job4_sb_empty", 256'(sb.size()), 256'(0));
    check("job4_done_pulses", 256'(done_cnt), 256'(1));

    // DW=8, 300 nonzeros of 127*127 per lane
    start_w = 1'b1;
    tick(1);
    start_w = 1'b0;
    n = 0;
    while (w_got != 3'b111 && n < 2000) begin tick(1); n++; end
    check("wide_results_seen", 256'(w_got), 256'(3'b111));
    check("wide_zero_flags", 256'(w_zero), 256'(0));
    for (int g = 0; g < 3; g++)
      for (int i = 0; i < (1 << g); i++)
        check($sformatf("wide_L%0d_lane%0d", 1 << g, i), 256'(w_cap[g][i*24 +: 24]), 256'(4838700));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/csr_spmv_lanes.md
CSR_SPMV_LANES -- requirements
Module: csr_spmv_lanes

Interface
REQ-001 SHALL have parameter LANES, default 2; number of dense vector channels multiplied in parallel (1..8).
REQ-002 SHALL have parameter DW, default 32; signed width of the sparse value and of each dense element.
REQ-003 SHALL have parameter AW, default 14; nonzero-index width. Parameter RW, default 10; row-index and column-index width.
REQ-004 SHALL have parameter ACCW, default 2*DW+8; signed accumulator width per lane.
REQ-005 SHALL have port clk, input, 1; single clock, all logic rising-edge.
REQ-006 SHALL have port rst, input, 1; asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1; one-cycle pulse that begins a job, sampled only in IDLE.
REQ-008 SHALL have port nrows, input, RW; number of matrix rows, sampled on start.
REQ-009 SHALL have port row_addr, output, RW; row-pointer memory address. row_data, input, AW; row_ptr word, 1-cycle read latency.
REQ-010 SHALL have port nz_addr, output, AW; value/column memory address. nz_val, input, DW, and nz_col, input, RW; both with 1-cycle latency.
REQ-011 SHALL have port vec_addr, output, RW; dense memory address. vec_data, input, LANES*DW; lane i in bits [i*DW +: DW], 1-cycle latency.
REQ-012 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_row (output, RW), out_data (output, LANES*ACCW), out_zero (output, 1); result stream.
REQ-013 SHALL have ports busy (output, 1) and done (output, 1).

Function
REQ-014 SHALL compute, for each row r in 0..nrows-1 and each lane i, y[r][i] = sum of nz_val[k]*x_i[nz_col[k]] for k from row_ptr[r] to row_ptr[r+1]-1, with all arithmetic signed.
REQ-015 SHALL use FSM states IDLE, PTR0, PTR1, MAC, DRAIN, EMIT, FIN.
- IDLE->PTR0 on start.
- PTR0 fetches row_ptr[r]; PTR1 fetches row_ptr[r+1].
- PTR1->MAC if the row is non-empty, else ->EMIT.
- MAC->DRAIN after the last nonzero is issued.
- DRAIN->EMIT when the pipeline is empty.
- EMIT->PTR0 (next row) or ->FIN on handshake.
- FIN->IDLE after one cycle.
REQ-016 SHALL issue one nonzero per cycle in MAC; the fixed MAC pipeline is nz_addr issue -> val/col (+1) -> vec_data (+2) -> registered product (+3) -> accumulator update (+4).
REQ-017 SHALL clear all LANES accumulators on entry to PTR0 and sign-extend products into ACCW; overflow wraps modulo 2^ACCW without any flag.
REQ-018 SHALL, for an empty row (row_ptr[r]==row_ptr[r+1]), emit out_data=0 with out_zero=1; out_zero SHALL be 0 for every other row.
REQ-019 SHALL hold out_valid, out_row, out_data and out_zero stable in EMIT until out_valid&&out_ready; no further memory reads are issued while stalled.
REQ-020 SHALL pulse done high for exactly one cycle in FIN, and SHALL hold busy=1 in every state except IDLE.
REQ-021 SHALL ignore start while busy; with nrows=0, SHALL go IDLE->FIN->IDLE, emitting nothing and pulsing done.
REQ-022 SHALL treat row_ptr values as absolute nz indices; a decreasing row_ptr pair is treated as an empty row.

Reset
REQ-023 SHALL, on rst low, immediately force the FSM to IDLE and drive busy, done, out_valid and out_zero to 0, and all addresses, out_row, out_data and the accumulators to 0, including mid-job; the aborted job produces no further output after rst is released.

Structure
REQ-024 SHALL place the FSM state enum, the MAC_LAT=4 constant and the default widths in shared package spmv_pkg.
REQ-025 SHALL instantiate one sub-module spmv_mac_lane per lane, generated by LANES; each holds the product register and accumulator, with clear/enable inputs.

Verification
REQ-026 SHALL cover a 3x3 matrix (rows {2,0,0},{0,0,0},{1,0,3}), LANES=2, x0={1,2,3}, x1={-1,4,5} -> rows 0,1,2 give {2,-2}, {0,0} with out_zero=1, and {10,14}; then a single done pulse.
REQ-027 SHALL cover out_ready held low for 10 cycles during row 0 -> outputs stable, no address change, and the correct result on release.
REQ-028 SHALL cover nrows=0 -> no out_valid, done 2 cycles after start, busy low 3 cycles after start.
REQ-029 SHALL cover rst asserted in MAC of row 1 of 4 -> all outputs 0 in the same cycle, and no out_valid until a new start.
REQ-030 SHALL cover DW=8, one row with 300 nonzeros each 127*127 -> per-lane result 4838700 (fits ACCW=24, signed range ±8388607); repeat with LANES=1 and LANES=4.
REQ-031 SHALL cover start asserted during busy -> ignored, and the job result unchanged.
